// File: rtl/axi_req_arbiter.sv
// Round-robin arbiter sharing one AXI driver request port between NUM_REQ requesters, one txn in flight.
// Latency: u_req_valid -> drv_req_valid 1 cycle, drv_done -> u_resp_valid 1 cycle; backpressure via drv_req_ready only.
module axi_req_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   localparam int STRB_W        = AXI_DATA_WIDTH / 8,
   localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                               M_AXI_ACLK,
   input  logic                               M_AXI_ARESET,
   input  logic [NUM_REQ-1:0]                 u_req_valid,
   input  logic [NUM_REQ-1:0]                 u_req_is_write,
   input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]  u_req_addr,
   input  logic [NUM_REQ*8-1:0]               u_req_len,
   input  logic [NUM_REQ*3-1:0]               u_req_size,
   input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]  u_req_wdata,
   input  logic [NUM_REQ*STRB_W-1:0]          u_req_wstrb,
   output logic [NUM_REQ-1:0]                 u_req_ready,
   output logic [NUM_REQ-1:0]                 u_resp_valid,
   output logic [AXI_DATA_WIDTH-1:0]          u_resp_rdata,
   output logic [1:0]                         u_resp_err,
   output logic                               drv_req_valid,
   output logic                               drv_req_is_write,
   output logic [AXI_ADDR_WIDTH-1:0]          drv_req_addr,
   output logic [7:0]                         drv_req_len,
   output logic [2:0]                         drv_req_size,
   output logic [AXI_DATA_WIDTH-1:0]          drv_req_wdata,
   output logic [STRB_W-1:0]                  drv_req_wstrb,
   input  logic                               drv_req_ready,
   input  logic                               drv_done,
   input  logic [AXI_DATA_WIDTH-1:0]          drv_rdata,
   input  logic [1:0]                         drv_resp,
   output logic                               busy,
   output logic [IDX_W-1:0]                   grant_idx
);

   localparam int CW = IDX_W + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   logic [1:0]                r_state;
   logic [IDX_W-1:0]          r_rr_ptr;
   logic [IDX_W-1:0]          r_grant_idx;
   logic                      r_wr;
   logic [AXI_ADDR_WIDTH-1:0] r_addr;
   logic [7:0]                r_len;
   logic [2:0]                r_size;
   logic [AXI_DATA_WIDTH-1:0] r_wdata;
   logic [STRB_W-1:0]         r_wstrb;
   logic [NUM_REQ-1:0]        r_resp_vld;
   logic [AXI_DATA_WIDTH-1:0] r_resp_rdata;
   logic [1:0]                r_resp_err;

   logic                      w_gnt_vld;
   logic [IDX_W-1:0]          w_gnt_idx;
   logic [NUM_REQ-1:0]        w_gnt_oh;
   logic [NUM_REQ-1:0]        w_done_oh;
   logic                      w_sel_wr;
   logic [AXI_ADDR_WIDTH-1:0] w_sel_addr;
   logic [7:0]                w_sel_len;
   logic [2:0]                w_sel_size;
   logic [AXI_DATA_WIDTH-1:0] w_sel_wdata;
   logic [STRB_W-1:0]         w_sel_wstrb;

   // Modulo-NUM_REQ add; the wide sum avoids power-of-two wrap for odd requester counts.
   function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base, input int off);
      logic [CW-1:0] s;
      s = {1'b0, base} + CW'(off);
      if (s >= CW'(NUM_REQ)) begin
         s = s - CW'(NUM_REQ);
      end
      return s[IDX_W-1:0];
   endfunction

   // Descending scan so the lowest offset from rr_ptr is the last writer and wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (u_req_valid[f_wrap(r_rr_ptr, k)]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = f_wrap(r_rr_ptr, k);
         end
      end
   end

   always_comb begin
      w_gnt_oh    = '0;
      w_done_oh   = '0;
      w_sel_wr    = 1'b0;
      w_sel_addr  = '0;
      w_sel_len   = '0;
      w_sel_size  = '0;
      w_sel_wdata = '0;
      w_sel_wstrb = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_done_oh[i] = (r_grant_idx == IDX_W'(i));
         if (w_gnt_idx == IDX_W'(i)) begin
            w_gnt_oh[i] = 1'b1;
            w_sel_wr    = u_req_is_write[i];
            w_sel_addr  = u_req_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            w_sel_len   = u_req_len[i*8 +: 8];
            w_sel_size  = u_req_size[i*3 +: 3];
            w_sel_wdata = u_req_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            w_sel_wstrb = u_req_wstrb[i*STRB_W +: STRB_W];
         end
      end
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         r_state      <= ST_IDLE;
         r_rr_ptr     <= '0;
         r_grant_idx  <= '0;
         r_wr         <= 1'b0;
         r_addr       <= '0;
         r_len        <= '0;
         r_size       <= '0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_resp_vld   <= '0;
         r_resp_rdata <= '0;
         r_resp_err   <= '0;
      end else begin
         r_resp_vld <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_vld) begin
                  r_grant_idx <= w_gnt_idx;
                  r_wr        <= w_sel_wr;
                  r_addr      <= w_sel_addr;
                  r_len       <= w_sel_len;
                  r_size      <= w_sel_size;
                  r_wdata     <= w_sel_wdata;
                  r_wstrb     <= w_sel_wstrb;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (drv_req_ready) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (drv_done) begin
                  r_resp_vld   <= w_done_oh;
                  r_resp_rdata <= drv_rdata;
                  r_resp_err   <= drv_resp;
                  r_rr_ptr     <= f_wrap(r_grant_idx, 1);
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign u_req_ready      = (r_state == ST_IDLE && w_gnt_vld && !M_AXI_ARESET) ? w_gnt_oh : '0;
   assign u_resp_valid     = r_resp_vld;
   assign u_resp_rdata     = r_resp_rdata;
   assign u_resp_err       = r_resp_err;
   assign drv_req_valid    = (r_state == ST_ISSUE);
   assign drv_req_is_write = r_wr;
   assign drv_req_addr     = r_addr;
   assign drv_req_len      = r_len;
   assign drv_req_size     = r_size;
   assign drv_req_wdata    = r_wdata;
   assign drv_req_wstrb    = r_wstrb;
   assign busy             = (r_state != ST_IDLE);
   assign grant_idx        = r_grant_idx;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Bench for axi_req_arbiter with three requesters: transaction-level model plus directed scenarios.
module tb_axi_req_arbiter;
   localparam int NR = 3;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int SW = DW / 8;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     u_req_valid, u_req_is_write, u_req_ready, u_resp_valid;
   logic [NR*AW-1:0]  u_req_addr;
   logic [NR*8-1:0]   u_req_len;
   logic [NR*3-1:0]   u_req_size;
   logic [NR*DW-1:0]  u_req_wdata;
   logic [NR*SW-1:0]  u_req_wstrb;
   logic [DW-1:0]     u_resp_rdata, drv_req_wdata, drv_rdata;
   logic [1:0]        u_resp_err, drv_resp;
   logic              drv_req_valid, drv_req_is_write, drv_req_ready, drv_done, busy;
   logic [AW-1:0]     drv_req_addr;
   logic [7:0]        drv_req_len;
   logic [2:0]        drv_req_size;
   logic [SW-1:0]     drv_req_wstrb;
   logic [IW-1:0]     grant_idx;

   axi_req_arbiter #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
      .u_req_valid(u_req_valid), .u_req_is_write(u_req_is_write), .u_req_addr(u_req_addr),
      .u_req_len(u_req_len), .u_req_size(u_req_size), .u_req_wdata(u_req_wdata),
      .u_req_wstrb(u_req_wstrb), .u_req_ready(u_req_ready), .u_resp_valid(u_resp_valid),
      .u_resp_rdata(u_resp_rdata), .u_resp_err(u_resp_err), .drv_req_valid(drv_req_valid),
      .drv_req_is_write(drv_req_is_write), .drv_req_addr(drv_req_addr), .drv_req_len(drv_req_len),
      .drv_req_size(drv_req_size), .drv_req_wdata(drv_req_wdata), .drv_req_wstrb(drv_req_wstrb),
      .drv_req_ready(drv_req_ready), .drv_done(drv_done), .drv_rdata(drv_rdata), .drv_resp(drv_resp),
      .busy(busy), .grant_idx(grant_idx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Transaction-level model: owner index (-1 when free), whether the driver took it, next preferred source.
   bit            m_known = 1'b0;
   int            m_owner, m_next, m_last, m_pulse;
   bit            m_issued;
   logic          m_wr;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_len;
   logic [2:0]    m_size;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [SW-1:0] m_wstrb;
   logic [1:0]    m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int win;
      logic [NR-1:0] e_rdy, e_resp;
      win = -1;
      for (int k = 0; k < NR; k++) begin
         int j;
         j = (m_next + k) % NR;
         if (win < 0 && u_req_valid[j]) win = j;
      end
      if (m_known) begin
         e_rdy  = '0;
         e_resp = '0;
         if (m_owner < 0 && win >= 0 && !rst) e_rdy[win] = 1'b1;
         if (m_pulse >= 0) e_resp[m_pulse] = 1'b1;
         chk("m_busy",      64'(busy),             64'(m_owner >= 0));
         chk("m_drv_vld",   64'(drv_req_valid),    64'(m_owner >= 0 && !m_issued));
         chk("m_grant_idx", 64'(grant_idx),        64'(m_last));
         chk("m_req_ready", 64'(u_req_ready),      64'(e_rdy));
         chk("m_resp_vld",  64'(u_resp_valid),     64'(e_resp));
         chk("m_resp_data", u_resp_rdata,          m_rdata);
         chk("m_resp_err",  64'(u_resp_err),       64'(m_err));
         chk("m_drv_wr",    64'(drv_req_is_write), 64'(m_wr));
         chk("m_drv_addr",  64'(drv_req_addr),     64'(m_addr));
         chk("m_drv_len",   64'(drv_req_len),      64'(m_len));
         chk("m_drv_size",  64'(drv_req_size),     64'(m_size));
         chk("m_drv_wdata", drv_req_wdata,         m_wdata);
         chk("m_drv_wstrb", 64'(drv_req_wstrb),    64'(m_wstrb));
      end
      if (rst) begin
         m_known = 1'b1; m_owner = -1; m_issued = 1'b0; m_next = 0; m_last = 0; m_pulse = -1;
         m_wr = 1'b0; m_addr = '0; m_len = '0; m_size = '0; m_wdata = '0; m_wstrb = '0;
         m_rdata = '0; m_err = '0;
      end else if (m_known) begin
         m_pulse = -1;
         if (m_owner < 0) begin
            if (win >= 0) begin
               m_owner = win; m_last = win; m_issued = 1'b0;
               m_wr    = u_req_is_write[win];
               m_addr  = u_req_addr[win*AW +: AW];
               m_len   = u_req_len[win*8 +: 8];
               m_size  = u_req_size[win*3 +: 3];
               m_wdata = u_req_wdata[win*DW +: DW];
               m_wstrb = u_req_wstrb[win*SW +: SW];
            end
         end else if (!m_issued) begin
            if (drv_req_ready) m_issued = 1'b1;
         end else if (drv_done) begin
            m_pulse = m_owner; m_rdata = drv_rdata; m_err = drv_resp;
            m_next  = (m_owner + 1) % NR;
            m_owner = -1;
         end
      end
   endtask

   // One clock: check/advance model at the falling edge, return just after the rising edge.
   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [DW-1:0] wd, input logic [SW-1:0] ws);
      u_req_is_write[i]        = wr;
      u_req_addr[i*AW +: AW]   = addr;
      u_req_len[i*8 +: 8]      = len;
      u_req_size[i*3 +: 3]     = size;
      u_req_wdata[i*DW +: DW]  = wd;
      u_req_wstrb[i*SW +: SW]  = ws;
   endtask

   task automatic serve(input logic [DW-1:0] rd, input logic [1:0] rsp, output int g);
      int n;
      n = 0;
      while (drv_req_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("issue_wait", 64'(drv_req_valid), 64'd1);
      g = int'(grant_idx);
      drv_req_ready = 1'b1; tick(); drv_req_ready = 1'b0;
      drv_done = 1'b1; drv_rdata = rd; drv_resp = rsp; tick(); drv_done = 1'b0;
   endtask

   initial begin
      int g;
      int gs [4];
      rst = 1'b1;
      u_req_valid = '0; u_req_is_write = '0; u_req_addr = '0; u_req_len = '0;
      u_req_size = '0; u_req_wdata = '0; u_req_wstrb = '0;
      drv_req_ready = 1'b0; drv_done = 1'b0; drv_rdata = '0; drv_resp = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant_idx), 64'd0);
      chk("rst_drv_vld", 64'(drv_req_valid), 64'd0);
      chk("rst_resp_vld", 64'(u_resp_valid), 64'd0);

      // single read from requester 1
      set_req(1, 1'b0, 32'h1000, 8'd0, 3'd3, '0, '0);
      u_req_valid = 3'b010;
      #1;
      chk("t1_ready", 64'(u_req_ready), 64'b010);
      chk("t1_drv_vld_c0", 64'(drv_req_valid), 64'd0);
      tick();
      u_req_valid = '0;
      chk("t1_drv_vld_c1", 64'(drv_req_valid), 64'd1);
      chk("t1_drv_addr", 64'(drv_req_addr), 64'h1000);
      serve(64'hDEADBEEF_CAFEF00D, 2'b00, g);
      chk("t1_grant", 64'(g), 64'd1);
      chk("t1_resp_vld", 64'(u_resp_valid), 64'b010);
      chk("t1_rdata", u_resp_rdata, 64'hDEADBEEF_CAFEF00D);
      tick();
      chk("t1_pulse_once", 64'(u_resp_valid), 64'd0);
      chk("t1_rdata_hold", u_resp_rdata, 64'hDEADBEEF_CAFEF00D);

      // contention between 0 and 1, both held valid
      set_req(0, 1'b0, 32'h0A00, 8'd3, 3'd3, '0, '0);
      u_req_valid = 3'b011;
      for (int t = 0; t < 4; t++) begin
         serve(64'(t + 100), 2'b00, gs[t]);
         if (t == 0) begin
            chk("t2_b2b_resp", 64'(u_resp_valid), 64'b001);
            chk("t2_b2b_ready", 64'(u_req_ready), 64'b010);
         end
      end
      u_req_valid = '0;
      chk("t2_g0", 64'(gs[0]), 64'd0);
      chk("t2_g1", 64'(gs[1]), 64'd1);
      chk("t2_g2", 64'(gs[2]), 64'd0);
      chk("t2_g3", 64'(gs[3]), 64'd1);
      tick();

      // driver backpressure on requester 2, valid dropped after grant
      set_req(2, 1'b0, 32'h2000, 8'd7, 3'd2, '0, '0);
      u_req_valid = 3'b100;
      tick();
      u_req_valid = '0;
      chk("t3_grant", 64'(grant_idx), 64'd2);
      for (int c = 0; c < 5; c++) begin
         chk("t3_hold_vld", 64'(drv_req_valid), 64'd1);
         chk("t3_hold_addr", 64'(drv_req_addr), 64'h2000);
         chk("t3_hold_len", 64'(drv_req_len), 64'd7);
         chk("t3_no_resp", 64'(u_resp_valid), 64'd0);
         tick();
      end
      chk("t3_vld_6th", 64'(drv_req_valid), 64'd1);
      drv_req_ready = 1'b1; tick(); drv_req_ready = 1'b0;
      chk("t3_accepted", 64'(drv_req_valid), 64'd0);
      drv_done = 1'b1; drv_rdata = 64'h55; drv_resp = 2'b00; tick(); drv_done = 1'b0;
      chk("t3_resp_vld", 64'(u_resp_valid), 64'b100);

      // wrap after index 2 and spurious completions
      drv_done = 1'b1; tick(); drv_done = 1'b0;
      chk("t5_idle_spur_resp", 64'(u_resp_valid), 64'd0);
      chk("t5_idle_spur_busy", 64'(busy), 64'd0);
      u_req_valid = 3'b111;
      tick();
      u_req_valid = '0;
      chk("t5_wrap_grant", 64'(grant_idx), 64'd0);
      drv_done = 1'b1; tick(); drv_done = 1'b0;
      chk("t5_issue_spur_vld", 64'(drv_req_valid), 64'd1);
      chk("t5_issue_spur_resp", 64'(u_resp_valid), 64'd0);
      serve(64'h0123, 2'b00, g);
      chk("t5_resp_vld", 64'(u_resp_valid), 64'b001);

      // write with error response from requester 0
      set_req(0, 1'b1, 32'h3000, 8'd0, 3'd3, 64'h11, 8'h0F);
      u_req_valid = 3'b001;
      tick();
      u_req_valid = '0;
      chk("t4_is_write", 64'(drv_req_is_write), 64'd1);
      chk("t4_wstrb", 64'(drv_req_wstrb), 64'h0F);
      chk("t4_wdata", drv_req_wdata, 64'h11);
      serve(64'hAAAA, 2'b10, g);
      chk("t4_grant", 64'(g), 64'd0);
      chk("t4_resp_vld", 64'(u_resp_valid), 64'b001);
      chk("t4_resp_err", 64'(u_resp_err), 64'd2);
      chk("t4_rdata", u_resp_rdata, 64'hAAAA);

      // reset while waiting for completion
      set_req(1, 1'b0, 32'h4000, 8'd1, 3'd3, '0, '0);
      u_req_valid = 3'b010;
      tick();
      u_req_valid = '0;
      drv_req_ready = 1'b1; tick(); drv_req_ready = 1'b0;
      chk("t6_waiting", 64'(busy), 64'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_resp_vld", 64'(u_resp_valid), 64'd0);
      chk("t6_drv_vld", 64'(drv_req_valid), 64'd0);
      chk("t6_grant", 64'(grant_idx), 64'd0);
      chk("t6_addr", 64'(drv_req_addr), 64'd0);
      drv_done = 1'b1; drv_rdata = 64'h77; tick(); drv_done = 1'b0;
      chk("t6_late_done", 64'(u_resp_valid), 64'd0);
      chk("t6_late_busy", 64'(busy), 64'd0);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
